// File: rtl/risc_pkg.sv
// Shared KGP-RISC control encodings: pc_control commands, branch types, sequencer states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package risc_pkg;

    // pc_control commands understood by program_counter; codes 4..15 are never driven
    localparam logic [3:0] PC_HOLD = 4'd0;
    localparam logic [3:0] PC_INC  = 4'd1;
    localparam logic [3:0] PC_JUMP = 4'd2;
    localparam logic [3:0] PC_JREG = 4'd3;

    localparam int unsigned WAIT_CNT_W = 8;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_B    = 3'd1,
        BR_BR   = 3'd2,
        BR_BZ   = 3'd3,
        BR_BNZ  = 3'd4,
        BR_BCY  = 3'd5,
        BR_BNCY = 3'd6,
        BR_BLTZ = 3'd7
    } br_type_e;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_HALT    = 3'd4,
        ST_FAULT   = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic sign;
    } alu_flags_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Handshake and command bundle between pc_sequencer and the fetch/decode/ALU/PC blocks.
// Latency: none (wires only).
// Backpressure: imem_req/imem_ack and ex_start/ex_done are the two stall points.
interface pc_sequencer_if;

    logic       imem_req;
    logic       imem_ack;
    logic       ir_load;
    logic       halt_instr;
    logic [2:0] br_type;
    logic       ex_start;
    logic       ex_done;
    logic       flag_zero;
    logic       flag_carry;
    logic       flag_sign;
    logic [3:0] pc_control;
    logic       branch_taken;
    logic       halted;
    logic       fault;

    // Sequencer side
    modport master (
        output imem_req, ir_load, ex_start, pc_control, branch_taken, halted, fault,
        input  imem_ack, halt_instr, br_type, ex_done, flag_zero, flag_carry, flag_sign
    );

    // Memory / decoder / ALU / PC side
    modport slave (
        input  imem_req, ir_load, ex_start, pc_control, branch_taken, halted, fault,
        output imem_ack, halt_instr, br_type, ex_done, flag_zero, flag_carry, flag_sign
    );

endinterface

// File: rtl/branch_resolve.sv
// Maps the latched branch type and ALU flags to the pc_control command issued in UPDATE.
// Latency: combinational.
// Backpressure: none.
module branch_resolve
    import risc_pkg::*;
(
    input  br_type_e   br_type,
    input  alu_flags_t flags,
    output logic [3:0] pc_control
);

    always_comb begin
        pc_control = PC_INC;
        case (br_type)
            BR_NONE: pc_control = PC_INC;
            BR_B:    pc_control = PC_JUMP;
            BR_BR:   pc_control = PC_JREG;
            BR_BZ:   pc_control = flags.zero  ? PC_JUMP : PC_INC;
            BR_BNZ:  pc_control = flags.zero  ? PC_INC  : PC_JUMP;
            BR_BCY:  pc_control = flags.carry ? PC_JUMP : PC_INC;
            BR_BNCY: pc_control = flags.carry ? PC_INC  : PC_JUMP;
            BR_BLTZ: pc_control = flags.sign  ? PC_JUMP : PC_INC;
            default: pc_control = PC_INC;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// FETCH/DECODE/EXECUTE/UPDATE sequencer driving program_counter; HALT and FAULT are terminal.
// Latency: 4 cycles minimum per instruction; outputs decode from registered state only.
// Backpressure: stalls in FETCH until imem_ack (faults after FETCH_TIMEOUT cycles), in EXECUTE until ex_done.
module pc_sequencer
    import risc_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(FETCH_TIMEOUT - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX  = '1;

    seq_state_e              state;
    seq_state_e              state_nxt;
    logic                    in_reset;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    ex_first;
    br_type_e                br_q;
    alu_flags_t              flags_q;
    logic [3:0]              pc_resolved;

    // in_reset holds outputs at their reset values for the cycle after rst is
    // sampled, so no output ever depends combinationally on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            in_reset <= 1'b1;
            wait_cnt <= '0;
            ex_first <= 1'b0;
            br_q     <= BR_NONE;
            flags_q  <= '0;
        end else begin
            in_reset <= 1'b0;
            state    <= state_nxt;
            ex_first <= (state == ST_DECODE) && (state_nxt == ST_EXECUTE);

            if ((state == ST_FETCH) && !in_reset) begin
                if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end

            if (state == ST_DECODE) begin
                br_q <= br_type_e'(bus.br_type);
            end

            if ((state == ST_EXECUTE) && bus.ex_done) begin
                flags_q <= '{zero: bus.flag_zero, carry: bus.flag_carry, sign: bus.flag_sign};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                // An ack on the timeout cycle still completes the fetch.
                if (!in_reset) begin
                    if (bus.imem_ack) begin
                        state_nxt = ST_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ST_FAULT;
                    end
                end
            end
            ST_DECODE:  state_nxt = bus.halt_instr ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE: state_nxt = bus.ex_done ? ST_UPDATE : ST_EXECUTE;
            ST_UPDATE:  state_nxt = ST_FETCH;
            ST_HALT:    state_nxt = ST_HALT;
            ST_FAULT:   state_nxt = ST_FAULT;
            default:    state_nxt = ST_FETCH;
        endcase
    end

    branch_resolve u_branch_resolve (
        .br_type    (br_q),
        .flags      (flags_q),
        .pc_control (pc_resolved)
    );

    assign bus.imem_req     = (state == ST_FETCH) && !in_reset;
    assign bus.ir_load      = (state == ST_DECODE);
    assign bus.ex_start     = (state == ST_EXECUTE) && ex_first;
    assign bus.pc_control   = (state == ST_UPDATE) ? pc_resolved : PC_HOLD;
    assign bus.branch_taken = (state == ST_UPDATE) && (pc_resolved != PC_INC);
    assign bus.halted       = (state == ST_HALT);
    assign bus.fault        = (state == ST_FAULT);

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle control FSM that sequences the `program_counter` block of the KGP-RISC core. It handles the instruction-memory fetch handshake, pulses instruction-register load and execute start, and resolves branches from the decoder's branch type and the ALU flags. It drives `pc_control` for exactly one cycle per instruction. It sits between the decoder/ALU and `program_counter`, and owns the `pc_control` encoding.

## Interface
Parameters:
- `FETCH_TIMEOUT`, default 16: maximum cycles spent in FETCH without `imem_ack` before a fault is raised; legal range 2..255.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_ack`  in  1  fetch complete; instruction word valid this cycle.
- `ir_load`  out  1  one-cycle pulse that loads the instruction register.
- `halt_instr`  in  1  decoder flags a halt instruction; sampled in DECODE.
- `br_type`  in  3  decoder branch type; sampled in DECODE.
- `ex_start`  out  1  one-cycle pulse that starts the ALU/execute stage.
- `ex_done`  in  1  execute complete; flags valid this cycle.
- `flag_zero`, `flag_carry`, `flag_sign`  in  1 each  ALU flags; sampled when `ex_done` is high.
- `pc_control`  out  4  command to `program_counter`.
- `branch_taken`  out  1  high in UPDATE when `pc_control` is not `PC_INC`.
- `halted`  out  1  sequencer is in HALT.
- `fault`  out  1  sequencer is in FAULT (fetch timeout).

## Operation
- `pc_control` encoding: `PC_HOLD`=0, `PC_INC`=1, `PC_JUMP`=2 (from `jump_address`), `PC_JREG`=3 (from `reg_address`). Values 4..15 are never driven.
- `br_type` encoding: 0 NONE, 1 B, 2 BR, 3 BZ, 4 BNZ, 5 BCY, 6 BNCY, 7 BLTZ.
- States and transitions:
  - FETCH: `imem_req`=1. Go to DECODE on `imem_ack`. Go to FAULT when the wait counter reaches `FETCH_TIMEOUT`-1 with no ack.
  - DECODE: `ir_load`=1 for one cycle. Latch `br_type`. Go to HALT if `halt_instr`=1, else go to EXECUTE.
  - EXECUTE: `ex_start`=1 in the first cycle only. On `ex_done`, latch the three flags and go to UPDATE.
  - UPDATE: drive the resolved `pc_control` for one cycle, then go to FETCH.
  - HALT and FAULT are terminal; only `rst` exits them.
- Resolution in UPDATE:
  - NONE → INC; B → JUMP; BR → JREG.
  - BZ → JUMP if zero, else INC. BNZ → JUMP if !zero, else INC.
  - BCY → JUMP if carry, else INC. BNCY → JUMP if !carry, else INC.
  - BLTZ → JUMP if sign, else INC.
- Outside UPDATE, `pc_control` = `PC_HOLD`.
- The wait counter clears on entry to FETCH. It is 8 bits and never wraps.

## Timing
- Reset values: state FETCH, `pc_control`=`PC_HOLD`, and `imem_req`, `ir_load`, `ex_start`, `branch_taken`, `halted`, `fault` all 0. `imem_req` rises in the first cycle after `rst` falls.
- `rst` high in any state, including mid-fetch, HALT or FAULT, returns to FETCH on the next edge. Latched `br_type` and flags clear to 0.
- All outputs decode from registered state and latches only. There is no combinational path from any input to any output.
- `imem_ack` counts only while in FETCH. An ack on the first FETCH cycle gives a 1-cycle fetch. An ack outside FETCH is ignored.
- `ex_done` counts in any EXECUTE cycle, including the `ex_start` cycle. `ex_done` outside EXECUTE is ignored.
- Minimum instruction period is 4 cycles (FETCH, DECODE, EXECUTE, UPDATE).
- The PC advances at the edge that ends UPDATE. It is therefore stable throughout the following FETCH.
- An ack arriving in the same cycle as the timeout count wins: go to DECODE, not FAULT.

## Structure
- Shared package `risc_pkg` holds:
  - `PC_HOLD`, `PC_INC`, `PC_JUMP`, `PC_JREG` (4-bit constants, shared with `program_counter`);
  - the `br_type` codes;
  - the state enum.
- Branch resolution is pure logic. It goes in sub-module `branch_resolve`, with inputs `br_type` and the flags and output `pc_control`. The FSM instantiates it.

## Test plan
- Reset then straight-line code, with `imem_ack` and `ex_done` immediate and `br_type`=0 → `pc_control`=1 for one cycle every 4 cycles, 0 otherwise; `ir_load` and `ex_start` each pulse once per instruction.
- `br_type`=3 with `flag_zero`=1, then with `flag_zero`=0 → UPDATE drives 2 (`branch_taken`=1), then 1 (`branch_taken`=0). Repeat for codes 4..7 with each flag polarity.
- `br_type`=2 → `pc_control`=3. `br_type`=1 → 2, independent of the flags.
- `imem_ack` withheld: with ack on cycle 15, state goes to DECODE; with ack never arriving, `fault`=1 after 16 FETCH cycles and `pc_control` stays 0 until `rst`.
- `halt_instr`=1 in DECODE → `halted`=1, `ex_start` is never pulsed, `pc_control` stays 0. Assert `rst` → FETCH and `imem_req`=1 one cycle after `rst` drops.
- `rst` asserted during EXECUTE with `ex_done` pending → no UPDATE occurs, and all outputs take their reset values the next cycle.
